// File: rtl/inst_loader.sv
// Byte-stream loader: packs bytes big-endian into 32-bit words and writes them from address 0,
// holding the CPU in reset meanwhile. Define INST_LOADER_CHKSUM_EN to require a sum-mod-256 trailer byte.
module inst_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   word_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
`ifdef INST_LOADER_CHKSUM_EN
        S_CHK  = 3'd2,
`endif
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_reg, state_next;
    logic [1:0]        byte_idx_reg;
    logic [23:0]       word_reg;
    logic [ADDR_W:0]   len_reg;
    logic [ADDR_W:0]   word_cnt_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_data_reg;
    logic              done_reg, err_reg, done_first_reg;
`ifdef INST_LOADER_CHKSUM_EN
    logic [7:0]        sum_reg;
`endif

    logic rx_open, accept, start_ok, len_bad, last_word, word_end;

    always_comb begin
        rx_open = (state_reg == S_LOAD);
`ifdef INST_LOADER_CHKSUM_EN
        rx_open = rx_open || (state_reg == S_CHK);
`endif
    end

    assign accept    = byte_valid_i && rx_open;
    assign start_ok  = start && (state_reg == S_IDLE || state_reg == S_DONE || state_reg == S_ERR);
    assign len_bad   = (len_i == '0) || (len_i > MAX_LEN);
    assign last_word = (word_cnt_reg == len_reg - 1'b1);
    assign word_end  = accept && (state_reg == S_LOAD) && (byte_idx_reg == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERR:
                if (start) state_next = len_bad ? S_ERR : S_LOAD;
            S_LOAD:
`ifdef INST_LOADER_CHKSUM_EN
                if (word_end && last_word) state_next = S_CHK;
            S_CHK:
                if (accept) state_next = (byte_i == sum_reg) ? S_DONE : S_ERR;
`else
                if (word_end && last_word) state_next = S_DONE;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // CPU reset is released one cycle after done rises so the final write has landed.
    always_comb begin
        byte_ready_o = rx_open;
        busy_o       = rx_open;
        cpu_rst_o    = rx_open || (state_reg == S_ERR) || (state_reg == S_DONE && done_first_reg);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx_reg   <= '0;
            word_reg       <= '0;
            len_reg        <= '0;
            word_cnt_reg   <= '0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_data_reg   <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            done_first_reg <= 1'b0;
`ifdef INST_LOADER_CHKSUM_EN
            sum_reg        <= '0;
`endif
        end else begin
            mem_we_reg     <= 1'b0;
            done_first_reg <= 1'b0;
            // The count advances at the end of the write cycle, so the write shows the old count.
            if (mem_we_reg) word_cnt_reg <= word_cnt_reg + 1'b1;
            if (accept && state_reg == S_LOAD) begin
                byte_idx_reg <= byte_idx_reg + 2'd1;
                word_reg     <= {word_reg[15:0], byte_i};
`ifdef INST_LOADER_CHKSUM_EN
                sum_reg      <= sum_reg + byte_i;
`endif
                if (byte_idx_reg == 2'd3) begin
                    mem_we_reg   <= 1'b1;
                    mem_addr_reg <= word_cnt_reg[ADDR_W-1:0];
                    mem_data_reg <= {word_reg, byte_i};
                end
            end
            if (state_reg != S_DONE && state_next == S_DONE) begin
                done_reg       <= 1'b1;
                done_first_reg <= 1'b1;
            end
            if (state_reg != S_ERR && state_next == S_ERR) err_reg <= 1'b1;
            if (start_ok) begin
                byte_idx_reg <= '0;
                word_cnt_reg <= '0;
                done_reg     <= 1'b0;
                err_reg      <= len_bad;
                len_reg      <= len_i;
`ifdef INST_LOADER_CHKSUM_EN
                sum_reg      <= '0;
`endif
            end
        end
    end

    assign mem_we_o   = mem_we_reg;
    assign mem_addr_o = mem_addr_reg;
    assign mem_data_o = mem_data_reg;
    assign done_o     = done_reg;
    assign err_o      = err_reg;
    assign word_cnt_o = word_cnt_reg;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed scenarios plus random loads checked against a byte-packing model.
module tb_inst_loader;
    localparam int ADDR_W = 10;
`ifdef INST_LOADER_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len_i = '0;
    logic [7:0]        byte_i = '0;
    logic              byte_valid_i = 1'b0;
    logic              byte_ready_o, mem_we_o, cpu_rst_o, busy_o, done_o, err_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_data_o;
    logic [ADDR_W:0]   word_cnt_o;

    inst_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len_i(len_i),
        .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .word_cnt_o(word_cnt_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0]        stim[$];
    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];

    always @(negedge clk) begin
        if (mem_we_o) begin
            wa_q.push_back(mem_addr_o);
            wd_q.push_back(mem_data_o);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic fill_stim(input int len);
        stim.delete();
        for (int i = 0; i < 4 * len; i++) stim.push_back(8'($urandom));
    endtask

    task automatic set_directed();
        stim = '{8'h3C, 8'h08, 8'h00, 8'h10, 8'h34, 8'h21, 8'h00, 8'h20};
    endtask

    task automatic push_trailer(input bit bad);
        logic [7:0] s;
        s = 8'h00;
        foreach (stim[i]) s = s + stim[i];
        stim.push_back(bad ? s + 8'h01 : s);
    endtask

    task automatic do_start(input int len);
        start = 1'b1;
        len_i = (ADDR_W+1)'(len);
        @(negedge clk);
        start = 1'b0;
        len_i = (ADDR_W+1)'($urandom);
    endtask

    // Offers stim[from..to]; mode 0 back-to-back, 1 valid every other cycle, 2 random valid.
    task automatic push_stream(input int from, input int to, input int mode);
        int i;
        int cyc;
        logic r, v;
        i = from;
        cyc = 0;
        while (i <= to && cyc < 2000) begin
            r = byte_ready_o;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom % 2);
            byte_valid_i = v;
            byte_i = v ? stim[i] : 8'($urandom);
            @(negedge clk);
            cyc++;
            if (r && v) i++;
        end
        byte_valid_i = 1'b0;
        chk("stream_progress", 64'(i), 64'(to + 1));
    endtask

    // Expected image: word k is bytes 4k..4k+3, first byte most significant, at address k.
    task automatic check_writes(input string tag, input int len);
        int n;
        chk({tag, "_nwrites"}, 64'(wa_q.size()), 64'(len));
        n = (wa_q.size() < len) ? wa_q.size() : len;
        for (int k = 0; k < n; k++) begin
            chk({tag, "_addr"}, 64'(wa_q[k]), 64'(k));
            chk({tag, "_data"}, 64'(wd_q[k]),
                64'({stim[4*k], stim[4*k+1], stim[4*k+2], stim[4*k+3]}));
        end
        clear_q();
    endtask

    task automatic run_load(input string tag, input int len, input int mode, input bit fill);
        if (fill) fill_stim(len);
        clear_q();
        do_start(len);
        chk({tag, "_done_cleared"}, 64'(done_o), 64'(0));
        if (CHK_EN) push_trailer(1'b0);
        push_stream(0, stim.size() - 1, mode);
        chk({tag, "_done"}, 64'(done_o), 64'(1));
        chk({tag, "_cpu_rst_hold"}, 64'(cpu_rst_o), 64'(1));
        @(negedge clk);
        chk({tag, "_cpu_rst_fall"}, 64'(cpu_rst_o), 64'(0));
        @(negedge clk);
        chk({tag, "_word_cnt"}, 64'(word_cnt_o), 64'(len));
        check_writes(tag, len);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({byte_ready_o, mem_we_o, mem_addr_o, mem_data_o, cpu_rst_o,
                    busy_o, done_o, err_o, word_cnt_o});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        chk("reset_outputs", all_outs(), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed two-word load with timing checks
        set_directed();
        clear_q();
        do_start(2);
        chk("dir_busy", 64'(busy_o), 64'(1));
        chk("dir_ready", 64'(byte_ready_o), 64'(1));
        chk("dir_cpu_rst", 64'(cpu_rst_o), 64'(1));
        if (CHK_EN) push_trailer(1'b0);
        push_stream(0, stim.size() - 1, 0);
`ifndef INST_LOADER_CHKSUM_EN
        chk("dir_last_we", 64'(mem_we_o), 64'(1));
        chk("dir_last_addr", 64'(mem_addr_o), 64'(1));
        chk("dir_last_data", 64'(mem_data_o), 64'h34210020);
`endif
        chk("dir_done", 64'(done_o), 64'(1));
        chk("dir_cpu_rst_hold", 64'(cpu_rst_o), 64'(1));
        chk("dir_busy_off", 64'(busy_o), 64'(0));
        @(negedge clk);
        chk("dir_cpu_rst_fall", 64'(cpu_rst_o), 64'(0));
        chk("dir_we_off", 64'(mem_we_o), 64'(0));
        chk("dir_addr_hold", 64'(mem_addr_o), 64'(1));
        chk("dir_data_hold", 64'(mem_data_o), 64'h34210020);
        chk("dir_word_cnt", 64'(word_cnt_o), 64'(2));
        @(negedge clk);
        check_writes("dir", 2);

        // Same image with valid toggling
        set_directed();
        run_load("toggle", 2, 1, 1'b0);

        // Illegal lengths
        for (int t = 0; t < 2; t++) begin
            clear_q();
            byte_valid_i = 1'b1;
            do_start(t == 0 ? 0 : 1025);
            chk("badlen_err", 64'(err_o), 64'(1));
            chk("badlen_cpu_rst", 64'(cpu_rst_o), 64'(1));
            chk("badlen_busy", 64'(busy_o), 64'(0));
            chk("badlen_ready", 64'(byte_ready_o), 64'(0));
            repeat (6) @(negedge clk);
            chk("badlen_cpu_rst_held", 64'(cpu_rst_o), 64'(1));
            chk("badlen_nwrites", 64'(wa_q.size()), 64'(0));
            byte_valid_i = 1'b0;
        end

        // start during LOAD is ignored
        fill_stim(1);
        clear_q();
        do_start(1);
        push_stream(0, 1, 0);
        start = 1'b1;
        len_i = 11'd5;
        @(negedge clk);
        start = 1'b0;
        chk("ign_err", 64'(err_o), 64'(0));
        if (CHK_EN) push_trailer(1'b0);
        push_stream(2, stim.size() - 1, 0);
        chk("ign_done", 64'(done_o), 64'(1));
        repeat (2) @(negedge clk);
        chk("ign_word_cnt", 64'(word_cnt_o), 64'(1));
        check_writes("ign", 1);

        // Random loads
        for (int t = 0; t < 5; t++) run_load("rand", int'($urandom_range(1, 6)), 2, 1'b1);

        // Reset mid-stream
        fill_stim(3);
        clear_q();
        do_start(3);
        push_stream(0, 4, 0);
        #2 rst = 1'b0;
        #1 chk("midrst_outputs", all_outs(), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        clear_q();
        run_load("after_rst", 1, 0, 1'b1);

`ifdef INST_LOADER_CHKSUM_EN
        // Trailer good and bad
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        clear_q();
        do_start(1);
        push_stream(0, 4, 0);
        chk("chk_ok_done", 64'(done_o), 64'(1));
        chk("chk_ok_err", 64'(err_o), 64'(0));
        repeat (2) @(negedge clk);
        chk("chk_ok_cpu_rst", 64'(cpu_rst_o), 64'(0));
        check_writes("chk_ok", 1);
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        do_start(1);
        push_stream(0, 4, 0);
        chk("chk_bad_err", 64'(err_o), 64'(1));
        chk("chk_bad_done", 64'(done_o), 64'(0));
        repeat (3) @(negedge clk);
        chk("chk_bad_cpu_rst", 64'(cpu_rst_o), 64'(1));
        chk("chk_bad_busy", 64'(busy_o), 64'(0));
        check_writes("chk_bad", 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Byte-stream loader that fills the instruction memory before the CPU runs. It accepts bytes over a valid/ready handshake and packs them big-endian into 32-bit words. It writes the words sequentially from address 0 into the instruction RAM write port, holding the CPU in reset while loading. It sits between a host byte source (UART receiver or debug bridge) and the write side of `inst_rom`; the CPU fetch path is the read side.

## Interface
- `ADDR_W`, 10, word-address width of instruction memory (matches `addra[11:2]`)
- `clk` in 1, system clock
- `rst` in 1, reset; asynchronous assert, active-low
- `start` in 1, one-cycle request to begin a load
- `len_i` in ADDR_W+1, number of 32-bit words to load; sampled on accepted `start`
- `byte_i` in 8, data byte
- `byte_valid_i` in 1, `byte_i` valid
- `byte_ready_o` out 1, loader can accept a byte
- `mem_we_o` out 1, instruction RAM write enable, one cycle per word
- `mem_addr_o` out ADDR_W, word address
- `mem_data_o` out 32, word to write
- `cpu_rst_o` out 1, active-high CPU reset request (`RstEnable` polarity)
- `busy_o` out 1, load in progress
- `done_o` out 1, last load completed OK; sticky until next `start`
- `err_o` out 1, last load failed; sticky until next `start`
- `word_cnt_o` out ADDR_W+1, words written in current/last load

## Operation
- States: IDLE, LOAD, CHK (only with macro), DONE, ERR. Every register is cleared by reset. All outputs are 0 at reset, and the state is IDLE.
- IDLE/DONE/ERR, `start`=1:
  - `len_i`==0 or `len_i` > 2**ADDR_W -> ERR, `err_o`=1.
  - Otherwise -> LOAD. Clear the byte index, `word_cnt_o` and `done_o`/`err_o`; latch `len_i`.
- `start` in LOAD or CHK is ignored.
- LOAD:
  - `byte_ready_o`=1, `busy_o`=1, `cpu_rst_o`=1.
  - A byte is accepted on an edge with `byte_valid_i`&&`byte_ready_o`.
  - Byte k (k=0..3) of a word goes to bits [31-8k:24-8k].
  - On acceptance of byte 3, the next cycle drives `mem_we_o`=1 with `mem_addr_o`=`word_cnt_o` (old value) and `mem_data_o`=assembled word, then `word_cnt_o` increments.
  - Byte acceptance continues during the write cycle; no bubble is required.
- Acceptance of byte 3 of word `len`-1 moves to DONE, or CHK with the macro. The final `mem_we_o` occurs in the first cycle of that state.
- DONE:
  - `done_o`=1, `busy_o`=0, `byte_ready_o`=0.
  - `cpu_rst_o` stays 1 for exactly one more cycle after `done_o` rises, then 0. The CPU therefore leaves reset after the last write has landed.
- ERR:
  - `err_o`=1, `busy_o`=0, `byte_ready_o`=0, `cpu_rst_o`=1 held, so the CPU never runs a partial image.
- `mem_addr_o`/`mem_data_o` hold their last values when `mem_we_o`=0.
- Reset mid-load: return immediately to IDLE with `cpu_rst_o`=0. Memory contents are undefined.

## Timing
- `start` at edge T -> `busy_o`/`byte_ready_o`=1 from T+1.
- Byte 3 accepted at edge E -> `mem_we_o` high for cycle E..E+1 only, and `word_cnt_o` updates at E+1.
- Throughput: one byte per cycle, so N words take 4N accepting cycles plus 1 trailing write cycle.
- `done_o` rises at the same edge as the final `mem_we_o`. `cpu_rst_o` falls one edge later.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `INST_LOADER_CHKSUM_EN` defined:
  - After the last data byte, enter CHK with `byte_ready_o`=1 and accept one trailer byte.
  - Trailer == sum mod 256 of all data bytes -> DONE. Otherwise -> ERR.
  - Any memory writes already made remain, but the CPU stays in reset.
- Undefined: the CHK state and the sum register are absent, and LOAD goes straight to DONE.

## Test plan
- Reset mid-stream: assert `rst` low after 5 bytes -> all outputs 0 asynchronously, `cpu_rst_o`=0, IDLE; next `start` loads from address 0.
- `start`, `len_i`=2, bytes 3C,08,00,10,34,21,00,20 back-to-back -> writes addr0=3C080010 and addr1=34210020, one cycle each. `done_o`=1 at the second write, `cpu_rst_o` falls one cycle later, `word_cnt_o`=2.
- Same load with `byte_valid_i` toggling every other cycle -> identical writes, and no byte is taken while `byte_valid_i`=0.
- `len_i`=0, and separately `len_i`=1025 with ADDR_W=10 -> `err_o`=1 next cycle, no `mem_we_o`, `cpu_rst_o`=1.
- `start` pulsed during LOAD after 2 bytes -> ignored; the load completes normally at its original length.
- With macro, `len_i`=1, bytes 01,02,03,04 then trailer 0A -> DONE. Same data with trailer 0B -> `err_o`=1 and `cpu_rst_o` held 1.
